// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and load/store.
// Data wins by default; a streak counter hands the RAM to a waiting fetch after MAX_STREAK data grants.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int RD_LAT     = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [1:0] LAT_M1     = 2'(RD_LAT - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   state_t          state, state_nxt;
   logic [1:0]      cnt, cnt_nxt;
   logic [3:0]      streak, streak_nxt;
   logic            owner_d, owner_d_nxt;
   logic            mem_en_nxt, mem_we_nxt;
   logic [AW-1:0]   mem_addr_nxt;
   logic [DW-1:0]   mem_wdata_nxt;
   logic            pick_d, pick_if;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("mem_arbiter: RD_LAT=%0d outside 1..4", RD_LAT);
   end
   if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_max_streak
      $error("mem_arbiter: MAX_STREAK=%0d outside 1..15", MAX_STREAK);
   end

   // Gated by rst so that no grant is visible while the block is held in reset.
   assign pick_d  = rst && d_req && !(if_req && streak == STREAK_MAX);
   assign pick_if = rst && if_req && !pick_d;

   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      streak_nxt    = streak;
      owner_d_nxt   = owner_d;
      mem_en_nxt    = mem_en;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      if_gnt        = 1'b0;
      d_gnt         = 1'b0;
      if_rvalid     = 1'b0;
      d_rvalid      = 1'b0;
      case (state)
         IDLE: begin
            if (pick_d) begin
               d_gnt         = 1'b1;
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = d_we;
               mem_addr_nxt  = d_addr;
               mem_wdata_nxt = d_wdata;
               owner_d_nxt   = 1'b1;
               state_nxt     = ISSUE;
               if (!if_req)
                  streak_nxt = 4'd0;
               else if (streak != STREAK_MAX)
                  streak_nxt = streak + 4'd1;
            end else if (pick_if) begin
               if_gnt        = 1'b1;
               mem_en_nxt    = 1'b1;
               mem_we_nxt    = 1'b0;
               mem_addr_nxt  = if_addr;
               mem_wdata_nxt = '0;
               owner_d_nxt   = 1'b0;
               streak_nxt    = 4'd0;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            mem_en_nxt = 1'b0;
            if (mem_we) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt   = LAT_M1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 2'd0) begin
               d_rvalid  = owner_d;
               if_rvalid = !owner_d;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         streak    <= 4'd0;
         owner_d   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         streak    <= streak_nxt;
         owner_d   <= owner_d_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
      end
   end

   a_single_gnt: assert property (@(posedge clk) disable iff (!rst) !(if_gnt && d_gnt))
      else $error("mem_arbiter: if_gnt and d_gnt asserted together");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (RD_LAT 1, 3, 4), each with a small RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req    [3];
   logic [31:0] if_addr   [3];
   logic        if_gnt    [3];
   logic        if_rvalid [3];
   logic [31:0] if_rdata  [3];
   logic        d_req     [3];
   logic        d_we      [3];
   logic [31:0] d_addr    [3];
   logic [31:0] d_wdata   [3];
   logic        d_gnt     [3];
   logic        d_rvalid  [3];
   logic [31:0] d_rdata   [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [31:0] mem_addr  [3];
   logic [31:0] mem_wdata [3];
   logic [31:0] mem_rdata [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
      logic [31:0] ram  [256];
      logic [31:0] pipe [4];

      mem_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .MAX_STREAK(4)) dut (
         .clk(clk), .rst(rst),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
         .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
         .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
         .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
      );

      initial begin
         for (int k = 0; k < 256; k++) ram[k] = 32'hC0FFEE00 | 32'(k);
         ram[8'h10] = 32'hDEADBEEF;
         for (int k = 0; k < 4; k++) pipe[k] = 32'h0;
      end

      // RAM: samples on the edge that sees mem_en, data appears LAT cycles later.
      always @(posedge clk) begin
         if (mem_en[g]) begin
            pipe[0] <= ram[mem_addr[g][7:0]];
            if (mem_we[g]) ram[mem_addr[g][7:0]] <= mem_wdata[g];
         end
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];
   end

   typedef struct {
      int          sel;
      logic        ifr;
      logic [31:0] ifa;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [5:0]  flags;   // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(int sel, logic ifr, logic [31:0] ifa, logic dr, logic dwe,
                               logic [31:0] da, logic [31:0] dwd, logic [5:0] flags,
                               logic [31:0] e_addr, logic [31:0] e_wdata, logic [31:0] e_rdata);
      vec_t v;
      v.sel = sel; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
      v.flags = flags; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 3; i++) begin
         if_req[i] = 1'b0; if_addr[i] = 32'h0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 32'h0; d_wdata[i] = 32'h0;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] flags_of(int s);
      return {if_gnt[s], d_gnt[s], if_rvalid[s], d_rvalid[s], mem_en[s], mem_we[s]};
   endfunction

   initial begin
      string       order;
      string       exp_order;
      int          both;
      int          got;
      logic [5:0]  fl;

      clear_inputs();
      rst = 1'b0;

      // Reset held with both requests pending: everything quiet.
      if_req[0] = 1'b1; if_addr[0] = 32'h10; d_req[0] = 1'b1; d_addr[0] = 32'h8;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("reset_flags", 32'(flags_of(0)), 32'h0);
         chk("reset_mem", mem_addr[0] | mem_wdata[0], 32'h0);
      end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("release_d_gnt", 32'({if_gnt[0], d_gnt[0]}), 32'b01);
      next_cycle();
      clear_inputs();
      repeat (4) next_cycle();

      // Single fetch, back-to-back fetches, store/load on RD_LAT=1; store/load on RD_LAT=3.
      tv.push_back(mk(0, 1, 32'h10, 0, 0, 0, 0,           6'b100000, 0,      0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b000010, 32'h10, 0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b001000, 0,      0,      32'hDEADBEEF));
      tv.push_back(mk(0, 1, 32'h20, 0, 0, 0, 0,           6'b100000, 0,      0,      0));
      tv.push_back(mk(0, 1, 32'h24, 0, 0, 0, 0,           6'b000010, 32'h20, 0,      0));
      tv.push_back(mk(0, 1, 32'h24, 0, 0, 0, 0,           6'b001000, 0,      0,      32'hC0FFEE20));
      tv.push_back(mk(0, 1, 32'h24, 0, 0, 0, 0,           6'b100000, 0,      0,      0));
      tv.push_back(mk(0, 1, 32'h28, 0, 0, 0, 0,           6'b000010, 32'h24, 0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b001000, 0,      0,      32'hC0FFEE24));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b000000, 0,      0,      0));
      tv.push_back(mk(0, 0, 0,      1, 1, 32'h30, 32'h55AA, 6'b010000, 0,    0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b000011, 32'h30, 32'h55AA, 0));
      tv.push_back(mk(0, 0, 0,      1, 0, 32'h30, 0,      6'b010001, 0,      0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b000010, 32'h30, 0,      0));
      tv.push_back(mk(0, 0, 0,      0, 0, 0, 0,           6'b000100, 0,      0,      32'h55AA));
      tv.push_back(mk(1, 0, 0,      1, 1, 32'h40, 32'h1234, 6'b010000, 0,    0,      0));
      tv.push_back(mk(1, 0, 0,      0, 0, 0, 0,           6'b000011, 32'h40, 32'h1234, 0));
      tv.push_back(mk(1, 0, 0,      1, 0, 32'h40, 0,      6'b010001, 0,      0,      0));
      tv.push_back(mk(1, 0, 0,      0, 0, 0, 0,           6'b000010, 32'h40, 0,      0));
      tv.push_back(mk(1, 0, 0,      0, 0, 0, 0,           6'b000000, 0,      0,      0));
      tv.push_back(mk(1, 0, 0,      0, 0, 0, 0,           6'b000000, 0,      0,      0));
      tv.push_back(mk(1, 0, 0,      0, 0, 0, 0,           6'b000100, 0,      0,      32'h1234));

      for (int r = 0; r < tv.size(); r++) begin
         int s;
         s = tv[r].sel;
         next_cycle();
         clear_inputs();
         if_req[s] = tv[r].ifr; if_addr[s] = tv[r].ifa;
         d_req[s] = tv[r].dr; d_we[s] = tv[r].dwe; d_addr[s] = tv[r].da; d_wdata[s] = tv[r].dwd;
         @(negedge clk);
         fl = flags_of(s);
         chk($sformatf("vec%0d_flags", r), 32'(fl), 32'(tv[r].flags));
         if (tv[r].flags[1]) begin
            chk($sformatf("vec%0d_addr", r), mem_addr[s], tv[r].e_addr);
            chk($sformatf("vec%0d_wdata", r), mem_wdata[s], tv[r].e_wdata);
         end
         if (tv[r].flags[3]) chk($sformatf("vec%0d_if_rdata", r), if_rdata[s], tv[r].e_rdata);
         if (tv[r].flags[2]) chk($sformatf("vec%0d_d_rdata", r), d_rdata[s], tv[r].e_rdata);
      end

      // Starvation bound: both requesters held continuously on the RD_LAT=1 instance.
      next_cycle();
      clear_inputs();
      if_req[0] = 1'b1; if_addr[0] = 32'h60; d_req[0] = 1'b1; d_addr[0] = 32'h70;
      order = "";
      both = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (if_gnt[0] && d_gnt[0]) both++;
         else if (d_gnt[0]) order = {order, "D"};
         else if (if_gnt[0]) order = {order, "F"};
         next_cycle();
      end
      clear_inputs();
      exp_order = "DDDDFDDDDF";
      chk("streak_both_gnt", 32'(both), 32'd0);
      chk("streak_count", 32'(order.len()), 32'd10);
      for (int k = 0; k < 10; k++) begin
         if (k < order.len()) chk($sformatf("streak_gnt%0d", k), 32'(order[k]), 32'(exp_order[k]));
         else chk($sformatf("streak_gnt%0d", k), 32'h0, 32'(exp_order[k]));
      end
      repeat (3) next_cycle();

      // Reset during ISSUE on the RD_LAT=4 instance: mem_en must drop without waiting for a clock.
      if_req[2] = 1'b1; if_addr[2] = 32'h50;
      @(negedge clk);
      chk("c_gnt_a", 32'(if_gnt[2]), 32'd1);
      next_cycle();
      if_req[2] = 1'b0;
      chk("c_issue_en", 32'(mem_en[2]), 32'd1);
      rst = 1'b0;
      #1;
      chk("c_async_en_issue", 32'(mem_en[2]), 32'd0);
      next_cycle();
      rst = 1'b1;

      // Reset during WAIT: the abandoned read never produces rvalid.
      next_cycle();
      if_req[2] = 1'b1; if_addr[2] = 32'h50;
      @(negedge clk);
      chk("c_gnt_b", 32'(if_gnt[2]), 32'd1);
      next_cycle();
      if_req[2] = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      chk("c_wait_en", 32'(mem_en[2]), 32'd0);
      next_cycle();
      rst = 1'b1;
      got = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (if_rvalid[2] || d_rvalid[2]) got++;
      end
      chk("c_no_rvalid", 32'(got), 32'd0);

      // Reissued fetch completes with rvalid in cycle 5.
      next_cycle();
      if_req[2] = 1'b1; if_addr[2] = 32'h50;
      @(negedge clk);
      chk("c_gnt_c", 32'(if_gnt[2]), 32'd1);
      next_cycle();
      if_req[2] = 1'b0;
      got = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (if_rvalid[2]) begin
            got = i;
            chk("c_rdata", if_rdata[2], 32'hC0FFEE50);
            break;
         end
      end
      chk("c_latency", 32'(got), 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU's instruction-fetch port and its load/store port, so the core runs from a unified memory instead of separate ROM and RAM blocks.
- Sequences each access through a fixed issue/wait/response FSM and arbitrates between the two requesters.
- Data accesses have priority; a streak counter bounds instruction-fetch starvation.
- Sits between the CPU's fetch/MEM-stage logic and the RAM block.

Parameters:
AW, 32, address width of requesters and RAM
DW, 32, data width
RD_LAT, 1, RAM read latency in cycles after the sampling edge; legal range 1..4
MAX_STREAK, 4, consecutive data grants allowed while a fetch waits; legal range 1..15

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  reset; asynchronous, active-low
if_req  input  1  fetch request; held with if_addr until if_gnt
if_addr  input  AW  fetch address
if_gnt  output  1  fetch grant; one-cycle pulse
if_rvalid  output  1  fetch read data valid; one-cycle pulse
if_rdata  output  DW  fetch read data
d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_gnt  output  1  data grant; one-cycle pulse
d_rvalid  output  1  load data valid; one-cycle pulse; never pulsed for stores
d_rdata  output  DW  load data
mem_en  output  1  RAM access strobe; registered
mem_we  output  1  RAM write enable; registered
mem_addr  output  AW  RAM address; registered
mem_wdata  output  DW  RAM write data; registered
mem_rdata  input  DW  RAM read data; valid RD_LAT cycles after the edge that samples mem_en

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- While rst=0:
  - State is IDLE, the streak counter is 0 and the owner flag is cleared.
  - mem_en, mem_we, mem_addr, mem_wdata are all 0.
  - All gnt and rvalid outputs are 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, winner selection (combinational on the current requests):
  - Winner is data if d_req=1, except fetch wins when if_req=1 and streak==MAX_STREAK.
  - With if_req only, fetch wins.
  - The winner's gnt is asserted combinationally in this cycle, which is cycle 0 of the transaction.
- IDLE, on the edge ending cycle 0:
  - mem_en<=1; mem_we<=(data winner ? d_we : 0).
  - mem_addr and mem_wdata are loaded from the winner; mem_wdata<=0 for a fetch.
  - The owner flag is recorded; state->ISSUE.
  - With no request, stay in IDLE with mem_en=0.
- ISSUE (cycle 1): mem_en=1 for exactly this one cycle; the RAM samples at the end of it.
  - Store: state->IDLE, so the next grant is possible in cycle 2.
  - Read: state->WAIT with cnt<=RD_LAT-1.
  - mem_en<=0 on leaving ISSUE. mem_addr, mem_we and mem_wdata hold their values until the next issue.
- WAIT:
  - If cnt==0: assert the owner's rvalid for one cycle and go to IDLE.
  - Otherwise cnt decrements.
  - Result: rvalid is asserted in cycle 1+RD_LAT, and the next grant is possible in cycle 2+RD_LAT.
- if_rdata and d_rdata are combinational copies of mem_rdata; they are meaningful only while the matching rvalid=1.
- No grant is given outside IDLE. Requests arriving during ISSUE/WAIT simply wait.
- Streak counter, updated on each grant edge:
  - Data grant with if_req=1: streak increments, saturating at MAX_STREAK.
  - Data grant with if_req=0: streak<=0.
  - Fetch grant: streak<=0.
- Simultaneous if_req and d_req with streak<MAX_STREAK: data wins, and the fetch stays pending.
- A request dropped before its grant is legal and has no effect. A request must not change its address or data while pending; the arbiter samples only at the grant edge.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Reset mid-transaction:
  - The transaction is abandoned; no rvalid is ever produced for it.
  - mem_en drops to 0 immediately (asynchronous).
  - Requesters reissue after reset is released.
- Simulation checks:
  - RD_LAT outside 1..4 or MAX_STREAK outside 1..15: $error at elaboration.
  - Any cycle with if_gnt and d_gnt both 1: $error.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both reqs=1 -> all outputs 0, no gnt; release rst -> d_gnt pulses in the first cycle after release.
- Single fetch, RD_LAT=1: if_req, if_addr=0x10 in cycle 0 -> if_gnt in cycle 0; mem_en=1, mem_addr=0x10, mem_we=0 in cycle 1; RAM returns 0xDEADBEEF -> if_rvalid=1, if_rdata=0xDEADBEEF in cycle 2; d_rvalid stays 0.
- Store then load, RD_LAT=3: store d_addr=0x40, d_wdata=0x1234 -> mem_we=1 in cycle 1, no d_rvalid, next d_gnt in cycle 2; load 0x40 granted in cycle 2 -> d_rvalid with 0x1234 exactly 4 cycles after that grant.
- Starvation bound, MAX_STREAK=4: d_req and if_req both held continuously -> grant order D,D,D,D,F,D,D,D,D,F; no cycle ever has both gnts.
- Reset mid-read, RD_LAT=4: assert rst=0 in the WAIT state -> mem_en=0 at once, no rvalid afterwards; the reissued fetch completes normally.
- Back-to-back fetches with d_req=0, RD_LAT=1 -> one fetch per 3 cycles; grants land in cycles 0, 3, 6.
